// File: rtl/canvas_buffer_pkg.sv
// Shared types, sizes and address helpers for the drawing canvas.
package canvas_pkg;

    localparam int CANVAS_DIM    = 32;
    localparam int CANVAS_ADDR_W = 10;

    typedef enum logic [1:0] {
        S_CLEAR  = 2'd0,
        S_DRAW   = 2'd1,
        S_SUBMIT = 2'd2,
        S_WAIT   = 2'd3
    } canvas_state_t;

    // Row part of a {row, col} canvas address.
    function automatic logic [4:0] addr_row(input logic [CANVAS_ADDR_W-1:0] addr);
        return addr[9:5];
    endfunction

    // Column part of a {row, col} canvas address.
    function automatic logic [4:0] addr_col(input logic [CANVAS_ADDR_W-1:0] addr);
        return addr[4:0];
    endfunction

    // Build a {row, col} canvas address.
    function automatic logic [CANVAS_ADDR_W-1:0] make_addr(input logic [4:0] row,
                                                           input logic [4:0] col);
        return {row, col};
    endfunction

endpackage

// File: rtl/canvas_buffer_if.sv
// Pen, request, recognizer and display signals of the canvas buffer.
interface canvas_buffer_if;
    import canvas_pkg::*;

    logic                     pen_valid;
    logic [4:0]               pen_x;
    logic [4:0]               pen_y;
    logic                     pen_erase;
    logic                     brush_big;
    logic                     clear_req;
    logic                     submit_req;
    logic                     recognizer_pending;
    logic                     end_write;
    logic                     read_enable;
    logic [CANVAS_ADDR_W-1:0] read_addr;
    logic                     read_in_data;
    logic [CANVAS_ADDR_W-1:0] vga_addr;
    logic                     vga_pixel;
    logic                     canvas_busy;
    logic                     dirty;

    modport master (
        output pen_valid, pen_x, pen_y, pen_erase, brush_big,
        output clear_req, submit_req, recognizer_pending,
        output read_enable, read_addr, vga_addr,
        input  end_write, read_in_data, vga_pixel, canvas_busy, dirty
    );

    modport slave (
        input  pen_valid, pen_x, pen_y, pen_erase, brush_big,
        input  clear_req, submit_req, recognizer_pending,
        input  read_enable, read_addr, vga_addr,
        output end_write, read_in_data, vga_pixel, canvas_busy, dirty
    );

endinterface

// File: rtl/canvas_brush_mask.sv
// Turns a pen sample into up to two row writes with column masks.
// Cells that fall off the right or bottom edge are dropped, never wrapped.
module canvas_brush_mask (
    input  logic [4:0]  pen_x,
    input  logic [4:0]  pen_y,
    input  logic        brush_big,
    output logic [4:0]  row0,
    output logic [4:0]  row1,
    output logic        row0_valid,
    output logic        row1_valid,
    output logic [31:0] mask0,
    output logic [31:0] mask1
);

    logic [5:0]  x_next;
    logic [5:0]  y_next;
    logic [31:0] col_mask;

    assign x_next = {1'b0, pen_x} + 6'd1;
    assign y_next = {1'b0, pen_y} + 6'd1;

    // Column mask shared by both rows; second row only exists for the big brush.
    always_comb begin
        col_mask = 32'd1 << pen_x;
        if (brush_big && !x_next[5]) begin
            col_mask = col_mask | (32'd1 << x_next[4:0]);
        end
        row0       = pen_y;
        row0_valid = 1'b1;
        mask0      = col_mask;
        row1       = y_next[4:0];
        row1_valid = brush_big && !y_next[5];
        mask1      = row1_valid ? col_mask : 32'd0;
    end

endmodule

// File: rtl/canvas_buffer.sv
// 32x32 1-bit drawing canvas with clear/submit sequencing and two read ports.
//
// state    | meaning
// S_CLEAR  | zeroing row rc each cycle, canvas busy
// S_DRAW   | idle, accepts clear/submit requests and pen writes
// S_SUBMIT | single end_write strobe cycle
// S_WAIT   | bitmap frozen until recognizer_pending drops
module canvas_buffer
    import canvas_pkg::*;
#(
    parameter int DIM_LOG2 = 5
) (
    input  logic            clk,
    input  logic            rst,
    canvas_buffer_if.slave  bus
);

    localparam int DIM = 1 << DIM_LOG2;

    canvas_state_t state;
    canvas_state_t next_state;
    logic [4:0]    rc;
    logic          dirty_q;
    logic          pen_we;

    logic [CANVAS_DIM-1:0] canvas_q [CANVAS_DIM];
    logic [CANVAS_DIM-1:0] canvas_d [CANVAS_DIM];

    logic [4:0]  row0;
    logic [4:0]  row1;
    logic        row0_valid;
    logic        row1_valid;
    logic [31:0] mask0;
    logic [31:0] mask1;

    canvas_brush_mask u_brush (
        .pen_x      (bus.pen_x),
        .pen_y      (bus.pen_y),
        .brush_big  (bus.brush_big),
        .row0       (row0),
        .row1       (row1),
        .row0_valid (row0_valid),
        .row1_valid (row1_valid),
        .mask0      (mask0),
        .mask1      (mask1)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_CLEAR;
        end else begin
            state <= next_state;
        end
    end

    // Next state and pen-write acceptance; clear beats submit beats pen.
    always_comb begin
        next_state = state;
        pen_we     = 1'b0;
        case (state)
            S_CLEAR: begin
                if (rc == 5'd31) begin
                    next_state = S_DRAW;
                end
            end
            S_DRAW: begin
                if (bus.clear_req) begin
                    next_state = S_CLEAR;
                end else if (bus.submit_req && dirty_q) begin
                    next_state = S_SUBMIT;
                end else if (bus.pen_valid) begin
                    pen_we = 1'b1;
                end
            end
            S_SUBMIT: begin
                next_state = S_WAIT;
            end
            S_WAIT: begin
                if (!bus.recognizer_pending) begin
                    next_state = S_DRAW;
                end
            end
            default: begin
                next_state = S_CLEAR;
            end
        endcase
    end

    // Clear row counter: runs only in S_CLEAR, parked at 0 elsewhere.
    always_ff @(posedge clk) begin
        if (rst) begin
            rc <= 5'd0;
        end else if (state == S_CLEAR) begin
            rc <= rc + 5'd1;
        end else begin
            rc <= 5'd0;
        end
    end

    // Dirty tracks any 1-write since the end of the last clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            dirty_q <= 1'b0;
        end else if (state == S_CLEAR && rc == 5'd31) begin
            dirty_q <= 1'b0;
        end else if (pen_we && !bus.pen_erase) begin
            dirty_q <= 1'b1;
        end
    end

    // Next canvas contents: clear row or apply the brush masks.
    always_comb begin
        for (int r = 0; r < DIM; r++) begin
            canvas_d[r] = canvas_q[r];
            if (state == S_CLEAR && rc == 5'(r)) begin
                canvas_d[r] = '0;
            end
            if (pen_we) begin
                if (row0_valid && row0 == 5'(r)) begin
                    canvas_d[r] = bus.pen_erase ? (canvas_d[r] & ~mask0)
                                                : (canvas_d[r] | mask0);
                end
                if (row1_valid && row1 == 5'(r)) begin
                    canvas_d[r] = bus.pen_erase ? (canvas_d[r] & ~mask1)
                                                : (canvas_d[r] | mask1);
                end
            end
        end
    end

    // Bitmap storage; contents are left alone during reset and wiped by S_CLEAR.
    always_ff @(posedge clk) begin
        if (!rst) begin
            canvas_q <= canvas_d;
        end
    end

    assign bus.read_in_data = bus.read_enable &&
                              canvas_q[addr_row(bus.read_addr)][addr_col(bus.read_addr)];
    assign bus.vga_pixel    = canvas_q[addr_row(bus.vga_addr)][addr_col(bus.vga_addr)];
    assign bus.end_write    = (state == S_SUBMIT);
    assign bus.canvas_busy  = (state != S_DRAW);
    assign bus.dirty        = dirty_q;

endmodule

// File: tb/tb_canvas_buffer.sv
// Directed bench for canvas_buffer: vector table for brush writes plus
// hand sequences for reset/clear timing, submit/wait and request priority.
module tb_canvas_buffer;
    import canvas_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    canvas_buffer_if bus();

    canvas_buffer #(.DIM_LOG2(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic       pen;
        logic [4:0] x;
        logic [4:0] y;
        logic       big;
        logic       erase;
        logic [9:0] probe;
        logic       exp;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic pen, input int x, input int y,
                                input logic big, input logic erase,
                                input int probe, input logic exp);
        vec_t v;
        v.pen = pen; v.x = 5'(x); v.y = 5'(y); v.big = big; v.erase = erase;
        v.probe = 10'(probe); v.exp = exp;
        return v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic scan_zero(input string name);
        int ones;
        ones = 0;
        for (int a = 0; a < 1024; a++) begin
            bus.vga_addr = 10'(a);
            #1;
            if (bus.vga_pixel !== 1'b0) ones++;
        end
        check(name, ones, 0);
    endtask

    initial begin
        int busy_cnt;
        int idle_cnt;
        int ew_cnt;
        int dirty_bad;

        bus.pen_valid = 0; bus.pen_x = 0; bus.pen_y = 0; bus.pen_erase = 0;
        bus.brush_big = 0; bus.clear_req = 0; bus.submit_req = 0;
        bus.recognizer_pending = 0; bus.read_enable = 0; bus.read_addr = 0;
        bus.vga_addr = 0;

        // pen, x, y, big, erase, probe, expected bit
        vecs.push_back(mk(1, 31, 31, 1, 0, 1023, 1));
        vecs.push_back(mk(0,  0,  0, 0, 0,    0, 0));
        vecs.push_back(mk(0,  0,  0, 0, 0,   31, 0));
        vecs.push_back(mk(0,  0,  0, 0, 0,  992, 0));
        vecs.push_back(mk(0,  0,  0, 0, 0, 1022, 0));
        vecs.push_back(mk(0,  0,  0, 0, 0,  991, 0));
        vecs.push_back(mk(1,  3,  4, 1, 0,  131, 1));
        vecs.push_back(mk(0,  0,  0, 0, 0,  132, 1));
        vecs.push_back(mk(0,  0,  0, 0, 0,  163, 1));
        vecs.push_back(mk(0,  0,  0, 0, 0,  164, 1));
        vecs.push_back(mk(0,  0,  0, 0, 0,  130, 0));
        vecs.push_back(mk(0,  0,  0, 0, 0,  165, 0));
        vecs.push_back(mk(0,  0,  0, 0, 0,   99, 0));
        vecs.push_back(mk(1, 10, 20, 0, 0,  650, 1));
        vecs.push_back(mk(0,  0,  0, 0, 0,  651, 0));
        vecs.push_back(mk(0,  0,  0, 0, 0,  682, 0));
        vecs.push_back(mk(1, 10, 20, 0, 1,  650, 0));
        vecs.push_back(mk(1, 31,  5, 1, 0,  191, 1));
        vecs.push_back(mk(0,  0,  0, 0, 0,  223, 1));
        vecs.push_back(mk(0,  0,  0, 0, 0,  160, 0));
        vecs.push_back(mk(0,  0,  0, 0, 0,  192, 0));
        vecs.push_back(mk(1,  0, 31, 1, 0,  992, 1));
        vecs.push_back(mk(0,  0,  0, 0, 0,  993, 1));
        vecs.push_back(mk(0,  0,  0, 0, 0,    0, 0));
        vecs.push_back(mk(0,  0,  0, 0, 0,    1, 0));

        // Reset and initial clear: 32 busy cycles, then idle with empty canvas.
        repeat (3) step();
        check("reset_busy", int'(bus.canvas_busy), 1);
        check("reset_end_write", int'(bus.end_write), 0);
        rst = 1'b0;
        busy_cnt = 0;
        dirty_bad = 0;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            if (bus.canvas_busy === 1'b1) busy_cnt++;
            if (bus.dirty !== 1'b0) dirty_bad++;
        end
        check("clear_busy_cycles", busy_cnt, 32);
        check("clear_dirty_low", dirty_bad, 0);
        @(negedge clk);
        check("clear_done_idle", int'(bus.canvas_busy), 0);
        scan_zero("reset_canvas_zero");

        // Table of brush writes and probes.
        bus.read_enable = 1'b1;
        foreach (vecs[i]) begin
            step();
            if (vecs[i].pen) begin
                bus.pen_valid = 1'b1;
                bus.pen_x     = vecs[i].x;
                bus.pen_y     = vecs[i].y;
                bus.brush_big = vecs[i].big;
                bus.pen_erase = vecs[i].erase;
                step();
                bus.pen_valid = 1'b0;
            end
            bus.vga_addr  = vecs[i].probe;
            bus.read_addr = vecs[i].probe;
            @(negedge clk);
            check($sformatf("vec%0d_vga_a%0d", i, vecs[i].probe),
                  int'(bus.vga_pixel), int'(vecs[i].exp));
            check($sformatf("vec%0d_rd_a%0d", i, vecs[i].probe),
                  int'(bus.read_in_data), int'(vecs[i].exp));
        end
        check("dirty_after_erase", int'(bus.dirty), 1);
        bus.read_enable = 1'b0;
        bus.read_addr   = 10'd1023;
        #1;
        check("read_enable_low", int'(bus.read_in_data), 0);
        bus.read_enable = 1'b1;

        // Submit while dirty; recognizer busy for 1024 cycles with pen writes at (0,0).
        step();
        bus.recognizer_pending = 1'b1;
        bus.submit_req = 1'b1;
        step();
        bus.submit_req = 1'b0;
        bus.pen_valid = 1'b1; bus.pen_x = 0; bus.pen_y = 0;
        bus.brush_big = 1'b0; bus.pen_erase = 1'b0;
        @(negedge clk);
        check("submit_end_write_first", int'(bus.end_write), 1);
        ew_cnt = 0;
        idle_cnt = 0;
        for (int i = 0; i < 1024; i++) begin
            if (i > 0) @(negedge clk);
            if (bus.end_write === 1'b1) ew_cnt++;
            if (bus.canvas_busy !== 1'b1) idle_cnt++;
        end
        check("submit_end_write_count", ew_cnt, 1);
        check("wait_busy_held", idle_cnt, 0);
        step();
        bus.pen_valid = 1'b0;
        step();
        bus.recognizer_pending = 1'b0;
        @(negedge clk);
        check("wait_busy_pending_drop_cycle", int'(bus.canvas_busy), 1);
        @(negedge clk);
        check("wait_release_idle", int'(bus.canvas_busy), 0);
        bus.read_addr = 10'd0;   #1; check("frozen_a0",   int'(bus.read_in_data), 0);
        bus.read_addr = 10'd131; #1; check("frozen_a131", int'(bus.read_in_data), 1);
        bus.read_addr = 10'd132; #1; check("frozen_a132", int'(bus.read_in_data), 1);
        bus.read_addr = 10'd163; #1; check("frozen_a163", int'(bus.read_in_data), 1);
        bus.read_addr = 10'd164; #1; check("frozen_a164", int'(bus.read_in_data), 1);

        // Clear and submit together: clear wins, no strobe, 32 busy cycles.
        check("dirty_before_clear", int'(bus.dirty), 1);
        step();
        bus.clear_req  = 1'b1;
        bus.submit_req = 1'b1;
        step();
        bus.clear_req  = 1'b0;
        bus.submit_req = 1'b0;
        ew_cnt = 0;
        busy_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.end_write === 1'b1) ew_cnt++;
            if (bus.canvas_busy === 1'b1) busy_cnt++;
        end
        check("clr_sub_end_write", ew_cnt, 0);
        check("clr_sub_busy_cycles", busy_cnt, 32);
        check("clr_sub_dirty", int'(bus.dirty), 0);
        scan_zero("clr_sub_canvas_zero");

        // Submit on a clean canvas is ignored.
        step();
        bus.submit_req = 1'b1;
        step();
        bus.submit_req = 1'b0;
        ew_cnt = 0;
        busy_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bus.end_write === 1'b1) ew_cnt++;
            if (bus.canvas_busy === 1'b1) busy_cnt++;
        end
        check("clean_submit_end_write", ew_cnt, 0);
        check("clean_submit_busy", busy_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
